// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory interface unit and its timeout counter.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 15;
  localparam int unsigned CNT_W           = $clog2(TIMEOUT_CYC_DEF + 1);

endpackage

// File: rtl/mem_interface_timeout_ctr.sv
// Loadable down-counter for the REQ-phase watchdog; expire pulses on the decrement that reaches zero.
module mem_timeout_ctr
  import mem_if_pkg::*;
#(
  parameter int unsigned W        = CNT_W,
  parameter int unsigned LOAD_VAL = TIMEOUT_CYC_DEF
) (
  input  logic clock,
  input  logic n_reset,
  input  logic load,
  input  logic dec,
  output logic expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(LOAD_VAL);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = dec && (cnt_q == W'(1));

endmodule

// File: rtl/mem_interface.sv
// Memory interface: owns MAR/MDR and turns sequencer CS/R_NW strobes into a req/ack transaction.
// Optional REQ watchdog with sticky bus_error is enabled by defining MEM_TIMEOUT_EN.
module mem_interface
  import mem_if_pkg::*;
#(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              CS,
  input  logic              R_NW,
  input  logic              load_MAR,
  input  logic              load_MDR,
  input  logic [WORD_W-1:0] sysbus,
  output logic [WORD_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              bus_error
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_interface: TIMEOUT_CYC must be at least 1");
  end

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic              rw_q, rw_d;

`ifdef MEM_TIMEOUT_EN
  logic bus_error_q, bus_error_d;
  logic tmo_expire;

  mem_timeout_ctr #(
    .W        ($clog2(TIMEOUT_CYC + 1)),
    .LOAD_VAL (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clock   (clock),
    .n_reset (n_reset),
    .load    ((state_q == IDLE) && CS),
    .dec     ((state_q == REQ) && !mem_ack),
    .expire  (tmo_expire)
  );
`endif

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rw_d    = rw_q;
`ifdef MEM_TIMEOUT_EN
    bus_error_d = bus_error_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_MAR) mar_d = sysbus[ADDR_W-1:0];
        if (load_MDR) mdr_d = sysbus;
        if (CS) begin
          rw_d    = R_NW;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack always wins over a coincident expiry.
        if (mem_ack) begin
          if (rw_q) mdr_d = mem_rdata;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_expire) begin
          if (rw_q) mdr_d = '1;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
`ifdef MEM_TIMEOUT_EN
      bus_error_q <= bus_error_d;
`endif
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = (state_q == REQ) && !rw_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mdr_out   = mdr_q;

  // DONE drops stall so the sequencer can leave its CS state without retriggering.
  always_comb begin
    case (state_q)
      IDLE:    stall = CS;
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: stimulus pushes expected transactions, a negedge monitor checks them.
module tb_mem_interface;

  logic       clock = 1'b0;
  logic       n_reset;
  logic       CS, R_NW, load_MAR, load_MDR;
  logic [7:0] sysbus;
  logic [7:0] mdr_out;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_req, mem_we;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       stall;
  logic       bus_error;

  mem_interface dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .CS        (CS),
    .R_NW      (R_NW),
    .load_MAR  (load_MAR),
    .load_MDR  (load_MDR),
    .sysbus    (sysbus),
    .mdr_out   (mdr_out),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .bus_error (bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] addr;
    logic       we;
    logic [7:0] wdata;
    int         n;
    logic [7:0] mdr;
    logic       berr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   req_cnt = 0;
  int   stall_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic we, input logic [7:0] wd,
                      input int n, input logic [7:0] mdr, input logic berr);
    exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.n = n; e.mdr = mdr; e.berr = berr;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic ld_mar(input logic [7:0] v);
    sysbus = v; load_MAR = 1'b1; step(); load_MAR = 1'b0;
  endtask

  task automatic ld_mdr(input logic [7:0] v);
    sysbus = v; load_MDR = 1'b1; step(); load_MDR = 1'b0;
  endtask

  // Starts in an IDLE cycle; spends n cycles in REQ, optionally acking in the last one.
  task automatic txn(input logic rw, input logic [7:0] rdata, input int n,
                     input logic ack, input logic keep_cs, input logic junk);
    CS = 1'b1; R_NW = rw;
    step();
    if (junk) begin
      load_MAR = 1'b1; load_MDR = 1'b1; sysbus = 8'hEE;
    end
    for (int i = 1; i <= n; i++) begin
      mem_ack   = ack && (i == n);
      mem_rdata = rdata;
      step();
    end
    mem_ack = 1'b0;
    CS      = keep_cs;
    step();
    load_MAR = 1'b0; load_MDR = 1'b0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (stall) stall_cnt++;
    if (mem_req) begin
      if (sb.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
      req_cnt++;
    end else if (req_cnt > 0) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("req_cycles", 32'(req_cnt), 32'(e.n));
        chk("stall_cycles", 32'(stall_cnt), 32'(e.n + 1));
        chk("mdr_after", 32'(mdr_out), 32'(e.mdr));
        chk("bus_error", 32'(bus_error), 32'(e.berr));
      end
      req_cnt   = 0;
      stall_cnt = 0;
    end else if (!stall) begin
      stall_cnt = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0; CS = 1'b0; R_NW = 1'b0; load_MAR = 1'b0; load_MDR = 1'b0;
    sysbus = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mdr_out", 32'(mdr_out), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_stall_lo", 32'(stall), 32'd0);
    CS = 1'b1; #1;
    chk("rst_stall_eq_cs", 32'(stall), 32'd1);
    CS = 1'b0;
    step();
    n_reset = 1'b1;
    step();

    // zero-wait read
    ld_mar(8'h13);
    push(5'h13, 1'b0, 8'h00, 1, 8'hA5, 1'b0);
    txn(1'b1, 8'hA5, 1, 1'b1, 1'b0, 1'b0);
    chk("read_mdr_idle", 32'(mdr_out), 32'hA5);
    step();

    // 3-wait write; rdata must not reach MDR
    ld_mdr(8'h5C);
    push(5'h13, 1'b1, 8'h5C, 4, 8'h5C, 1'b0);
    txn(1'b0, 8'h77, 4, 1'b1, 1'b0, 1'b0);
    step();

    // CS held through DONE: second transaction starts right after DONE
    ld_mar(8'h07);
    push(5'h07, 1'b0, 8'h5C, 2, 8'h11, 1'b0);
    push(5'h07, 1'b0, 8'h11, 1, 8'h22, 1'b0);
    txn(1'b1, 8'h11, 2, 1'b1, 1'b1, 1'b0);
    txn(1'b1, 8'h22, 1, 1'b1, 1'b0, 1'b0);
    step();

    // reset during the second REQ cycle
    ld_mar(8'h1F);
    push(5'h1F, 1'b0, 8'h22, 2, 8'h00, 1'b0);
    CS = 1'b1; R_NW = 1'b1;
    step();
    step();
    n_reset = 1'b0; CS = 1'b0;
    step();
    n_reset = 1'b1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_mdr", 32'(mdr_out), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    step(); step();
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_mdr", 32'(mdr_out), 32'd0);
    mem_ack = 1'b0;
    step();

    // loads during REQ/DONE ignored; capture beats load_MDR
    ld_mar(8'h0A);
    ld_mdr(8'h44);
    push(5'h0A, 1'b0, 8'h44, 2, 8'h3C, 1'b0);
    txn(1'b1, 8'h3C, 2, 1'b1, 1'b0, 1'b1);
    chk("junk_addr_idle", 32'(mem_addr), 32'h0A);
    chk("junk_mdr_idle", 32'(mdr_out), 32'h3C);
    step();

`ifdef MEM_TIMEOUT_EN
    // timeout read, then a good read keeps bus_error sticky
    ld_mar(8'h02);
    push(5'h02, 1'b0, 8'h3C, 15, 8'hFF, 1'b1);
    txn(1'b1, 8'h00, 15, 1'b0, 1'b0, 1'b0);
    push(5'h02, 1'b0, 8'hFF, 1, 8'h5A, 1'b1);
    txn(1'b1, 8'h5A, 1, 1'b1, 1'b0, 1'b0);
    chk("berr_sticky", 32'(bus_error), 32'd1);
`else
    chk("berr_tied_low", 32'(bus_error), 32'd0);
`endif

    step(); step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
